// File: rtl/program_sequencer_if.sv
// Sequencer command/status bundle.
// master = instruction controller, slave = program_sequencer.
interface program_sequencer_if #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
);
  localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

  logic [2:0]         pc_control;
  logic [INSTR_W-1:0] instruction;
  logic               z_flag;
  logic               c_flag;
  logic               stall;
  logic [ADDR_W-1:0]  iram_address;
  logic [LVL_W-1:0]   stack_level;
  logic               stack_err;

  modport master (
    output pc_control,
    output instruction,
    output z_flag,
    output c_flag,
    output stall,
    input  iram_address,
    input  stack_level,
    input  stack_err
  );

  modport slave (
    input  pc_control,
    input  instruction,
    input  z_flag,
    input  c_flag,
    input  stall,
    output iram_address,
    output stack_level,
    output stack_err
  );
endinterface

// File: rtl/program_sequencer.sv
// Program counter sequencer with conditional jump/call,
// return stack and sticky stack-fault flag.
module program_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic clock,
  input  logic reset,
  program_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL =
    LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_nxt;
  logic [LVL_W-1:0]  lvl_q;
  logic [LVL_W-1:0]  lvl_nxt;
  logic              err_q;
  logic              err_nxt;
  logic [ADDR_W-1:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] target;
  logic [3:0]        cond;
  logic              cond_ok;
  logic [ADDR_W-1:0] pc_inc;
  logic [LVL_W-1:0]  lvl_inc;
  logic [LVL_W-1:0]  lvl_dec;
  logic [ADDR_W-1:0] top;
  logic              full;
  logic              empty;
  logic              push;

  logic is_inc;
  logic is_jmp;
  logic is_call;
  logic is_ret;

  assign target  = bus.instruction[ADDR_W-1:0];
  assign cond    = bus.instruction[ADDR_W+3:ADDR_W];
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign lvl_inc = lvl_q + LVL_W'(1);
  assign lvl_dec = lvl_q - LVL_W'(1);
  assign top     = stack[lvl_dec[PTR_W-1:0]];
  assign full    = (lvl_q == FULL_LVL);
  assign empty   = (lvl_q == '0);

  // Upper opcode bits are not part of sequencing.
  generate
    if (INSTR_W > ADDR_W + 4) begin : g_spare
      logic unused_hi;
      assign unused_hi =
        ^bus.instruction[INSTR_W-1:ADDR_W+4];
    end
  endgenerate

  always_comb begin
    is_inc  = (bus.pc_control == 3'b001);
    is_jmp  = (bus.pc_control == 3'b010);
    is_call = (bus.pc_control == 3'b011);
    is_ret  = (bus.pc_control == 3'b100);
  end

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = 1'b1;
      4'b0001: cond_ok = ~bus.z_flag;
      4'b0010: cond_ok = bus.z_flag;
      4'b0011: cond_ok = ~bus.c_flag;
      4'b0100: cond_ok = bus.c_flag;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt  = pc_q;
    lvl_nxt = lvl_q;
    err_nxt = err_q;
    push    = 1'b0;
    unique case (1'b1)
      is_inc: pc_nxt = pc_inc;
      is_jmp: begin
        if (cond_ok) pc_nxt = target;
      end
      is_call: begin
        if (cond_ok) begin
          if (full) begin
            err_nxt = 1'b1;
          end else begin
            push    = 1'b1;
            pc_nxt  = target;
            lvl_nxt = lvl_inc;
          end
        end
      end
      is_ret: begin
        if (empty) begin
          err_nxt = 1'b1;
        end else begin
          pc_nxt  = top;
          lvl_nxt = lvl_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      lvl_q <= '0;
      err_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q  <= pc_nxt;
      lvl_q <= lvl_nxt;
      err_q <= err_nxt;
    end
  end

  // Entry storage is unreachable after reset, so it is not cleared.
  always_ff @(posedge clock) begin
    if (!reset && !bus.stall && push) begin
      stack[lvl_q[PTR_W-1:0]] <= pc_inc;
    end
  end

  assign bus.iram_address = pc_q;
  assign bus.stack_level  = lvl_q;
  assign bus.stack_err    = err_q;
endmodule
